bcd_scan_counter: RTL

- Multi-digit BCD up/down counter with a built-in display scanner, sitting directly upstream of the BCD-to-7-segment decoder.
- Each scan slot presents one 4-bit BCD digit on digit_out, which feeds the decoder input, plus a one-hot digit select for the display's common lines.
- The count advances on an internal prescaled tick. The scanner time-multiplexes the digits at an independent rate.

---
 rtl/bcd_scan_counter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: multi-digit BCD up/down counter with a built-in display scanner.
//
// Parameters:
//   NUM_DIGITS  number of BCD digits (1..8), digit 0 least significant
//   PRESCALE    clk cycles per count tick (>=2)
//   SCAN_DIV    clk cycles per scan slot (>=2)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           count enable, gates the prescaler
//   up           direction, 1 = up, 0 = down
//   clear        synchronous clear of count and prescaler (highest priority)
//   load         synchronous load of load_val (nibbles >9 load as 0)
//   load_val     packed BCD load value, nibble i is digit i
//   count        packed current BCD count
//   wrap         one-cycle pulse on roll-over / roll-under
//   digit_out    BCD digit of the current scan slot, to the 7-segment decoder
//   digit_sel    one-hot active-high select of the current slot
//   digit_blank  slot is a blanked leading zero
//
// Optional feature: define BCD_LEADING_ZERO_BLANK_EN to build leading-zero
// blanking; otherwise digit_blank is tied to 0.
module bcd_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    digit_blank
);
  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(PRESCALE);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [PW-1:0]         pre_q, pre_d;
  logic [CW-1:0]         count_q, count_d, step, ld;
  logic                  wrap_q, wrap_d, carry, tick;
  logic [3:0]            dig;
  logic [SW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  adv_q, scan_adv;
  logic [3:0]            out_q, out_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  assign tick     = en && (pre_q == PW'(PRESCALE - 1));
  assign scan_adv = div_q == SW'(SCAN_DIV - 1);
  // Ripple carry/borrow through the digits; carry out of the top digit is the wrap.
  always_comb begin
    step  = count_q;
    ld    = '0;
    carry = 1'b1;
    dig   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig              = count_q[4*i +: 4];
      step[4*i +: 4]   = !carry ? dig :
                         up ? (dig == 4'd9 ? 4'd0 : dig + 4'd1) :
                              (dig == 4'd0 ? 4'd9 : dig - 4'd1);
      carry            = carry && (up ? dig == 4'd9 : dig == 4'd0);
      ld[4*i +: 4]     = load_val[4*i +: 4] > 4'd9 ? 4'd0 : load_val[4*i +: 4];
    end
  end
  always_comb begin
    count_d = clear ? '0 : load ? ld : tick ? step : count_q;
    wrap_d  = !clear && !load && tick && carry;
    pre_d   = (clear || load) ? '0 : !en ? pre_q : tick ? '0 : pre_q + PW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end
  assign count = count_q;
  assign wrap  = wrap_q;
  // Scan slot outputs are refreshed only in the cycle after an index advance,
  // so a count change mid-slot is not seen until the next slot.
  always_comb begin
    div_d = scan_adv ? '0 : div_q + SW'(1);
    idx_d = !scan_adv ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
    out_d = out_q;
    sel_d = adv_q ? NUM_DIGITS'(1) << idx_q : sel_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (adv_q && idx_q == IW'(i)) out_d = count_q[4*i +: 4];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      adv_q <= 1'b0;
      out_q <= '0;
      sel_q <= NUM_DIGITS'(1);
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      adv_q <= scan_adv;
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end
  assign digit_out = out_q;
  assign digit_sel = sel_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic                  blank_q, blank_d, hz;
  logic [NUM_DIGITS-1:0] hi_zero;
  // hi_zero[i]: digit i and every more significant digit are zero.
  always_comb begin
    hz      = 1'b1;
    hi_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hz         = hz && count_q[4*i +: 4] == 4'd0;
      hi_zero[i] = hz;
    end
    blank_d = blank_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (adv_q && idx_q == IW'(i)) blank_d = (i != 0) && hi_zero[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= 1'b0;
    else        blank_q <= blank_d;
  end
  assign digit_blank = blank_q;
`else
  assign digit_blank = 1'b0;
`endif
endmodule
